// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures high time and period of an asynchronous PWM stream with ready/valid output and stuck detection
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pwm_in              asynchronous PWM input
//   out_ready           consumer accepts the held measurement
//   out_valid           a measurement is held on high_cnt/period_cnt
//   high_cnt            clk cycles pwm_in was high in the measured period
//   period_cnt          clk cycles between two consecutive rising edges
//   overrun             sticky flag, a completed measurement was dropped
//   stuck               00 toggling, 01 stuck low, 10 stuck high, 11 never driven
module pwm_duty_decoder #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             overrun,
    output logic [1:0]       stuck
);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    typedef enum logic [1:0] {WAIT_RISE, HIGH, LOW, TIMEOUT} state_t;
    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic [CNT_W-1:0]       hcnt, pcnt, wcnt;
    logic                   s, rise, fall, complete;
    assign s        = sync[SYNC_STAGES-1];
    assign rise     = s & ~prev;
    assign fall     = ~s & prev;
    // saturation takes priority over a completing edge in the same cycle
    assign complete = (state == LOW) && rise && (pcnt != MAX);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pwm_in};
            prev <= s;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_RISE;
            hcnt  <= '0;
            pcnt  <= '0;
            wcnt  <= '0;
            stuck <= 2'b00;
        end else begin
            case (state)
                WAIT_RISE: begin
                    if (rise) begin
                        state <= HIGH;
                        hcnt  <= ONE;
                        pcnt  <= ONE;
                        stuck <= 2'b00;
                    end else if (wcnt == MAX) begin
                        stuck <= 2'b11;
                    end else begin
                        wcnt <= wcnt + ONE;
                    end
                end
                HIGH: begin
                    if (pcnt == MAX) begin
                        state <= TIMEOUT;
                        stuck <= s ? 2'b10 : 2'b01;
                    end else begin
                        pcnt <= pcnt + ONE;
                        if (fall) state <= LOW;
                        else hcnt <= hcnt + ONE;
                    end
                end
                LOW: begin
                    if (pcnt == MAX) begin
                        state <= TIMEOUT;
                        stuck <= s ? 2'b10 : 2'b01;
                    end else if (rise) begin
                        // back-to-back periods: the completing edge starts the next one
                        state <= HIGH;
                        hcnt  <= ONE;
                        pcnt  <= ONE;
                    end else begin
                        pcnt <= pcnt + ONE;
                    end
                end
                default: begin
                    if (rise) begin
                        state <= HIGH;
                        hcnt  <= ONE;
                        pcnt  <= ONE;
                        stuck <= 2'b00;
                    end else begin
                        stuck <= s ? 2'b10 : 2'b01;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            high_cnt   <= '0;
            period_cnt <= '0;
            overrun    <= 1'b0;
        end else if (complete) begin
            // a completion coinciding with a transfer replaces the held data
            if (!out_valid || out_ready) begin
                out_valid  <= 1'b1;
                high_cnt   <= hcnt;
                period_cnt <= pcnt;
            end else begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
